latency_timer: RTL and testbench
================================

LATENCY_TIMER -- requirements
Module: latency_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the latency counter and of the result and limit registers (8..16).
REQ-002 SHALL have parameter PULSE_W, default 4, giving the stimulus pulse width in clk cycles (>=1).
REQ-003 SHALL have port clk  in  1  sole clock, all state on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port address  in  2  Avalon-MM slave word address.
REQ-006 SHALL have port write  in  1  Avalon write strobe.
REQ-007 SHALL have port writedata  in  16  Avalon write data.
REQ-008 SHALL have port readdata  out  16  Avalon read data, registered.
REQ-009 SHALL have port stim  out  1  stimulus pulse to the device under measurement.
REQ-010 SHALL have port resp  in  1  asynchronous response from the device under measurement.
REQ-011 SHALL have port irq  out  1  completion interrupt (see Configuration).

Function
REQ-012 SHALL update readdata every cycle from the register selected by address, giving 1-cycle read latency; unused bits read 0.
REQ-013 SHALL map registers: 0 CTRL/STATUS; 1 LATENCY (RO); 2 LIMIT (RW); 3 COUNT (RO). Writes to RO addresses are ignored.
REQ-014 SHALL decode CTRL writes as bit0 start, bit1 abort, bit2 irq_ack, and return STATUS reads as bit0 busy, bit1 done, bit2 timeout, bit3 irq.
REQ-015 SHALL synchronize resp through two flops and detect its rising edge against a third registered copy; total synchronizer latency is 2 cycles.
REQ-016 SHALL implement FSM IDLE -> STIM -> WAIT -> IDLE; busy=1 in STIM and WAIT.
REQ-017 SHALL, in IDLE on start, clear the counter, done and timeout, and enter STIM on the next cycle.
REQ-018 SHALL drive stim=1 for exactly PULSE_W cycles in STIM, then enter WAIT with stim=0.
REQ-019 SHALL increment the counter once per cycle in STIM and WAIT, starting at 0 in the first stim cycle.
REQ-020 SHALL, on a detected edge in STIM or WAIT, load LATENCY with the counter value, set done, increment COUNT (wrapping mod 2^16) and return to IDLE; an edge in STIM ends the pulse early.
REQ-021 SHALL, when the counter equals LIMIT without an edge, load LATENCY with LIMIT, set timeout, leave COUNT unchanged and return to IDLE.
REQ-022 SHALL, on abort in STIM or WAIT, return to IDLE with stim=0, leaving LATENCY, COUNT, done and timeout unchanged.
REQ-023 SHALL ignore start while busy; start and abort in the same cycle SHALL act as abort only.
REQ-024 SHALL, on an edge and a LIMIT match in the same cycle, treat the event as done rather than timeout.
REQ-025 SHALL ignore resp edges while in IDLE.
REQ-026 SHALL apply a LIMIT write during a measurement from the next cycle; a LIMIT below the current counter SHALL time out when the counter wraps back to it.

Reset
REQ-027 SHALL, while reset_n=0 at a clk edge, enter IDLE with stim=0, readdata=0, LATENCY=0, COUNT=0, LIMIT=all ones, done=timeout=irq=0, and synchronizer flops cleared.
REQ-028 SHALL abandon any measurement in progress when reset is applied mid-operation.

Configuration
REQ-029 SHALL, with LATENCY_TIMER_IRQ_EN defined, set irq on done or timeout and clear it on irq_ack or an accepted start; irq_ack has priority over a same-cycle set.
REQ-030 SHALL, without LATENCY_TIMER_IRQ_EN, tie irq to 0, read STATUS bit3 as 0 and ignore irq_ack.

Structure
REQ-031 SHALL take the FSM state enum, register address constants, CTRL/STATUS bit positions and SYNC_LAT=2 from shared package latency_timer_pkg.
REQ-032 SHALL place the synchronizer and edge detector in sub-module sync_edge_det; all other logic SHALL be in latency_timer.

Verification
REQ-033 SHALL verify: start, resp rises 10 cycles after stim rises -> LATENCY=12, done=1, COUNT=1, stim high for 4 cycles.
REQ-034 SHALL verify: LIMIT=20, start, resp never rises -> timeout=1 after the counter reaches 20, LATENCY=20, COUNT unchanged.
REQ-035 SHALL verify: start, abort 5 cycles later -> stim=0 next cycle, busy=0, LATENCY and COUNT unchanged; then start with resp at +3 -> LATENCY=5.
REQ-036 SHALL verify: start during WAIT, start+abort together, and resp edges in IDLE -> no restart, abort wins, no state change respectively.
REQ-037 SHALL verify: with LATENCY_TIMER_IRQ_EN, completion -> irq=1; CTRL=0x4 -> irq=0; irq_ack in the completion cycle -> irq stays 0; without the macro, irq=0 throughout.
REQ-038 SHALL verify: reset_n low during WAIT -> next cycle IDLE, stim=0, LIMIT=0xFFFF, readdata=0.

Source files
------------

// File: rtl/latency_timer_pkg.sv
// rtl/latency_timer_pkg.sv - shared types and constants for the latency timer
//
// Purpose : FSM state encoding, register map, CTRL/STATUS bit positions and
//           the resp synchronizer depth, plus a STATUS word packing helper.
// Ports   : none (package).
// Config  : LATENCY_TIMER_IRQ_EN is consumed by latency_timer, not here.

package latency_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STIM = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Register word addresses
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_LATENCY = 2'd1;
  localparam logic [1:0] ADDR_LIMIT   = 2'd2;
  localparam logic [1:0] ADDR_COUNT   = 2'd3;

  // CTRL write bits
  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_ABORT_BIT   = 1;
  localparam int CTRL_IRQ_ACK_BIT = 2;

  // STATUS read bits
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_IRQ_BIT     = 3;

  // Flops between resp and the edge detector's compare point
  localparam int SYNC_LAT = 2;

  function automatic logic [15:0] pack_status(input logic busy,
                                              input logic done,
                                              input logic timeout,
                                              input logic irq);
    logic [15:0] s;
    s                   = '0;
    s[STAT_BUSY_BIT]    = busy;
    s[STAT_DONE_BIT]    = done;
    s[STAT_TIMEOUT_BIT] = timeout;
    s[STAT_IRQ_BIT]     = irq;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - resp synchronizer and rising-edge detector
//
// Purpose : brings the asynchronous response into the clk domain through a
//           SYNC_LAT-deep flop chain and flags a rising edge by comparing the
//           last chain stage with one further registered copy.
// Ports   : clk_i     in  clock
//           reset_ni  in  synchronous active-low reset, clears all flops
//           async_i   in  asynchronous level input
//           edge_o    out one-cycle pulse, SYNC_LAT cycles after async_i rises

module sync_edge_det
  import latency_timer_pkg::*;
(
  input  logic clk_i,
  input  logic reset_ni,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_LAT-1:0] sync_q;
  logic [SYNC_LAT-1:0] sync_d;
  logic                prev_q;

  assign sync_d = {sync_q[SYNC_LAT-2:0], async_i};

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_LAT-1];
    end
  end

  assign edge_o = sync_q[SYNC_LAT-1] & ~prev_q;

endmodule

// File: rtl/latency_timer.sv
// rtl/latency_timer.sv - stimulus/response latency measurement block
//
// Purpose : on a CTRL start, drives a PULSE_W-cycle stimulus pulse and counts
//           clk cycles until the synchronized response rises (done) or the
//           counter reaches LIMIT (timeout). Results sit in Avalon-MM
//           readable registers.
// Ports   : clk        in   sole clock
//           reset_n    in   synchronous active-low reset
//           address    in   [1:0] register word address
//           write      in   write strobe
//           writedata  in   [15:0] write data
//           readdata   out  [15:0] registered read data (1-cycle latency)
//           stim       out  stimulus pulse
//           resp       in   asynchronous response
//           irq        out  completion interrupt
// Config  : define LATENCY_TIMER_IRQ_EN to enable the interrupt; otherwise
//           irq is tied low, STATUS bit3 reads 0 and irq_ack is ignored.

module latency_timer
  import latency_timer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        stim,
  input  logic        resp,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  // The cycle counter starts at 0 on the first stim cycle, so it doubles as
  // the pulse-length counter while in STIM.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  latency_q;
  logic [CNT_W-1:0]  limit_q;
  logic [15:0]       count_q;
  logic              done_q;
  logic              timeout_q;
  logic              stim_q;
  logic [15:0]       readdata_q;
  logic [15:0]       readdata_d;

  logic resp_edge;
  logic ctrl_wr;
  logic start_req;
  logic abort_req;
  logic busy;
  logic start_acc;
  logic meas_done;
  logic meas_timeout;
  logic irq_flag;

  sync_edge_det u_sync_edge_det (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .async_i  (resp),
    .edge_o   (resp_edge)
  );

  assign ctrl_wr   = write && (address == ADDR_CTRL);
  assign start_req = ctrl_wr && writedata[CTRL_START_BIT];
  assign abort_req = ctrl_wr && writedata[CTRL_ABORT_BIT];
  assign busy      = (state_q != ST_IDLE);

  // Start is only taken from IDLE and loses to a same-cycle abort.
  assign start_acc = start_req && !abort_req && !busy;

  // Completion events; abort outranks both, and an edge outranks a limit hit.
  assign meas_done    = busy && !abort_req && resp_edge;
  assign meas_timeout = busy && !abort_req && !resp_edge && (cnt_q == limit_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      latency_q <= '0;
      limit_q   <= '1;
      count_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      stim_q    <= 1'b0;
    end else begin
      // A LIMIT write takes effect on the following cycle, even mid-run.
      if (write && (address == ADDR_LIMIT)) begin
        limit_q <= writedata[CNT_W-1:0];
      end

      case (state_q)
        ST_IDLE: begin
          if (start_acc) begin
            cnt_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            stim_q    <= 1'b1;
            state_q   <= ST_STIM;
          end
        end

        ST_STIM, ST_WAIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (abort_req) begin
            stim_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (meas_done) begin
            latency_q <= cnt_q;
            done_q    <= 1'b1;
            count_q   <= count_q + 16'd1;
            stim_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (meas_timeout) begin
            latency_q <= limit_q;
            timeout_q <= 1'b1;
            stim_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end else if ((state_q == ST_STIM) && (cnt_q == PULSE_LAST)) begin
            stim_q  <= 1'b0;
            state_q <= ST_WAIT;
          end
        end

        default: begin
          stim_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef LATENCY_TIMER_IRQ_EN
  logic irq_ack;
  logic irq_d;
  logic irq_q;

  assign irq_ack = ctrl_wr && writedata[CTRL_IRQ_ACK_BIT];

  // Clear terms are applied last so an ack in the completion cycle wins.
  always_comb begin
    irq_d = irq_q;
    if (meas_done || meas_timeout) begin
      irq_d = 1'b1;
    end
    if (irq_ack || start_acc) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_flag = irq_q;
`else
  assign irq_flag = 1'b0;
`endif

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_CTRL:    readdata_d = pack_status(busy, done_q, timeout_q, irq_flag);
      ADDR_LATENCY: readdata_d = 16'(latency_q);
      ADDR_LIMIT:   readdata_d = 16'(limit_q);
      ADDR_COUNT:   readdata_d = count_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign stim     = stim_q;
  assign irq      = irq_flag;

endmodule

// File: tb/tb_latency_timer.sv
// tb/tb_latency_timer.sv - self-checking bench for latency_timer

module tb_latency_timer;

  localparam int CNT_W   = 16;
  localparam int PULSE_W = 4;
`ifdef LATENCY_TIMER_IRQ_EN
  localparam int IRQ_EN = 1;
`else
  localparam int IRQ_EN = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        write;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        stim;
  logic        resp;
  logic        irq;

  int vectors;
  int miscompares;

  latency_timer #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .stim      (stim),
    .resp      (resp),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  // limit, resp_at (cycle after start, -1 never), ctrl_at/ctrl_val (one CTRL
  // write during the run), then expected latency/done/timeout/count/stim
  // cycles/busy cycles/irq (irq as if the interrupt were enabled)
  typedef struct {
    int lim; int resp_at; int ctrl_at; int ctrl_val;
    int lat; int done; int to; int cnt; int stim_c; int busy_c; int irq_e;
  } vec_t;

  vec_t tbl [14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    address   = a;
    writedata = d[15:0];
    write     = 1'b1;
    tick();
    write     = 1'b0;
    address   = 2'd0;
    writedata = 16'd0;
  endtask

  task automatic rd(input logic [1:0] a, output int v);
    address = a;
    tick();
    v = int'(readdata);
    address = 2'd0;
  endtask

  // Runs one measurement; cycle 0 is the first stim cycle.
  task automatic run_meas(input string tag, input int lim, input int resp_at,
                          input int ctrl_at, input int ctrl_val,
                          output int stim_c, output int busy_c);
    int fin;
    wr(2'd2, lim);
    wr(2'd0, 1);
    stim_c = 0;
    busy_c = 0;
    fin    = 0;
    for (int n = 0; n < 200; n++) begin
      if (stim) stim_c++;
      if (n > 0) begin
        // readdata now shows STATUS of cycle n-1
        if (readdata[0]) busy_c++;
        else begin
          fin = 1;
          break;
        end
      end
      resp = (resp_at >= 0) && (n >= resp_at);
      if (n == ctrl_at) begin
        address   = 2'd0;
        writedata = ctrl_val[15:0];
        write     = 1'b1;
      end else begin
        write = 1'b0;
      end
      tick();
    end
    write = 1'b0;
    resp  = 1'b0;
    chk({tag, "_terminates"}, fin, 1);
    repeat (4) tick();
  endtask

  task automatic check_state(input string tag, input int lat, input int done,
                             input int to, input int irq_e, input int cnt);
    int v;
    rd(2'd0, v);
    chk({tag, "_status"}, v, (irq_e << 3) | (to << 2) | (done << 1));
    rd(2'd1, v);
    chk({tag, "_latency"}, v, lat);
    rd(2'd3, v);
    chk({tag, "_count"}, v, cnt);
    chk({tag, "_irq_pin"}, int'(irq), irq_e);
  endtask

  initial begin
    int v, sc, bc, fin;
    int lim, d, e, nat_end, sel, cval, cat, m_end, m_lat, m_cnt, m_done, m_to, m_irq;
    string tag;

    vectors = 0;
    miscompares = 0;

    tbl[0]  = '{32'hFFFF, 10, -1, 0, 12, 1, 0, 1, 4, 13, 1};
    tbl[1]  = '{20,       -1, -1, 0, 20, 0, 1, 1, 4, 21, 1};
    tbl[2]  = '{32'hFFFF, -1,  5, 2, 20, 0, 0, 1, 4,  6, 0};
    tbl[3]  = '{32'hFFFF,  3, -1, 0,  5, 1, 0, 2, 4,  6, 1};
    tbl[4]  = '{32'hFFFF,  0, -1, 0,  2, 1, 0, 3, 3,  3, 1};
    tbl[5]  = '{7,         5, -1, 0,  7, 1, 0, 4, 4,  8, 1};
    tbl[6]  = '{0,        -1, -1, 0,  0, 0, 1, 4, 1,  1, 1};
    tbl[7]  = '{32'hFFFF,  3,  5, 2,  0, 0, 0, 4, 4,  6, 0};
    tbl[8]  = '{3,        -1, -1, 0,  3, 0, 1, 4, 4,  4, 1};
    tbl[9]  = '{32'hFFFF, 12,  8, 1, 14, 1, 0, 5, 4, 15, 1};
    tbl[10] = '{32'hFFFF, 12,  8, 3, 14, 0, 0, 5, 4,  9, 0};
    tbl[11] = '{32'hFFFF,  4,  6, 4,  6, 1, 0, 6, 4,  7, 0};
    tbl[12] = '{32'hFFFF,  4,  7, 4,  6, 1, 0, 7, 4,  7, 0};
    tbl[13] = '{9,        -1,  0, 2,  6, 0, 0, 7, 1,  1, 0};

    reset_n = 1'b0; address = 2'd0; write = 1'b0; writedata = 16'd0; resp = 1'b0;
    repeat (3) tick();
    chk("reset_readdata", int'(readdata), 0);
    chk("reset_stim", int'(stim), 0);
    chk("reset_irq", int'(irq), 0);
    reset_n = 1'b1;
    rd(2'd2, v);
    chk("reset_limit", v, 32'hFFFF);
    check_state("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("row%0d", i);
      run_meas(tag, tbl[i].lim, tbl[i].resp_at, tbl[i].ctrl_at, tbl[i].ctrl_val, sc, bc);
      chk({tag, "_stim_cycles"}, sc, tbl[i].stim_c);
      chk({tag, "_busy_cycles"}, bc, tbl[i].busy_c);
      check_state(tag, tbl[i].lat, tbl[i].done, tbl[i].to, IRQ_EN & tbl[i].irq_e, tbl[i].cnt);
    end

    // Completion raises irq, then a CTRL irq_ack clears it.
    run_meas("ack", 32'hFFFF, 2, -1, 0, sc, bc);
    check_state("ack_pre", 4, 1, 0, IRQ_EN, 8);
    wr(2'd0, 4);
    chk("ack_irq_cleared", int'(irq), 0);

    // resp edges while idle must not change anything.
    for (int k = 0; k < 3; k++) begin
      resp = 1'b1;
      repeat (3) tick();
      chk("idle_edge_stim", int'(stim), 0);
      resp = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
    check_state("idle_edges", 4, 1, 0, 0, 8);

    // LIMIT rewritten mid-measurement takes effect next cycle.
    wr(2'd2, 32'hFFFF);
    wr(2'd0, 1);
    repeat (10) tick();
    wr(2'd2, 15);
    fin = 0;
    for (int k = 0; k < 40; k++) begin
      rd(2'd0, v);
      if ((v & 1) == 0) begin
        fin = 1;
        break;
      end
    end
    chk("limit_live_terminates", fin, 1);
    check_state("limit_live", 15, 0, 1, IRQ_EN, 8);

    // Reset in the middle of WAIT.
    wr(2'd2, 30);
    wr(2'd0, 1);
    repeat (8) tick();
    chk("pre_reset_stim", int'(stim), 0);
    reset_n = 1'b0;
    tick();
    chk("midreset_stim", int'(stim), 0);
    chk("midreset_readdata", int'(readdata), 0);
    reset_n = 1'b1;
    rd(2'd2, v);
    chk("midreset_limit", v, 32'hFFFF);
    check_state("midreset", 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("midreset_stim_after", int'(stim), 0);

    // Randomized measurements against an arithmetic outcome model.
    m_lat = 0;
    m_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      lim     = int'($urandom_range(0, 40));
      d       = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 45));
      e       = (d < 0) ? 1000 : d + 2;
      nat_end = (e < lim) ? e : lim;
      sel     = int'($urandom_range(0, 4));
      case (sel)
        0:       begin cval = 0; cat = -1; end
        1:       begin cval = 2; cat = int'($urandom_range(0, nat_end + 1)); end
        2:       begin cval = 3; cat = int'($urandom_range(0, nat_end + 1)); end
        3:       begin cval = 4; cat = int'($urandom_range(0, nat_end + 1)); end
        default: begin cval = 1; cat = int'($urandom_range(0, nat_end)); end
      endcase

      m_done = 0;
      m_to   = 0;
      if (((cval & 2) != 0) && (cat <= nat_end)) begin
        m_end = cat;
      end else if (e <= lim) begin
        m_end  = e;
        m_lat  = e;
        m_done = 1;
        m_cnt  = (m_cnt + 1) % 65536;
      end else begin
        m_end = lim;
        m_lat = lim;
        m_to  = 1;
      end
      m_irq = IRQ_EN & (m_done | m_to) & ~((cval == 4 && cat >= m_end) ? 1 : 0);

      tag = $sformatf("rnd%0d", k);
      run_meas(tag, lim, d, cat, cval, sc, bc);
      chk({tag, "_stim_cycles"}, sc, (m_end + 1 < PULSE_W) ? m_end + 1 : PULSE_W);
      chk({tag, "_busy_cycles"}, bc, m_end + 1);
      check_state(tag, m_lat, m_done, m_to, m_irq, m_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
